// File: rtl/morse_pkg.sv
// Shared types and the default Morse table (letters I-P) for morse_tx_core.
// Patterns are stored bit 0 first: dot = 1, dash = 111, intra-symbol gap = 0.
package morse_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam int unsigned TblW    = 16;
  localparam int unsigned TblLenW = 5;

  function automatic logic [TblW-1:0] tbl_pattern(input int unsigned idx);
    case (idx)
      0:       return 16'h0005;  // I ..
      1:       return 16'h1DDD;  // J .---
      2:       return 16'h01D7;  // K -.-
      3:       return 16'h015D;  // L .-..
      4:       return 16'h0077;  // M --
      5:       return 16'h0017;  // N -.
      6:       return 16'h0777;  // O ---
      7:       return 16'h05DD;  // P .--.
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [TblLenW-1:0] tbl_len(input int unsigned idx);
    case (idx)
      0:       return 5'd3;
      1:       return 5'd13;
      2:       return 5'd9;
      3:       return 5'd9;
      4:       return 5'd7;
      5:       return 5'd5;
      6:       return 5'd11;
      7:       return 5'd11;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/morse_tx_rate_divider.sv
// Unit-tick generator: counts DIV-1 down to 0 while enabled, tick marks the zero cycle.
module rate_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(DIV - 1);
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? CntW'(DIV - 1) : cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/morse_tx_core.sv
// Morse transmitter: plays a table pattern bit 0 first at one bit per unit, then a gap,
// optionally repeating. All outputs are registered from the next-state values.
module morse_tx_core
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned NUM_SYM   = 8,
  parameter int unsigned GAP_UNITS = 3,
  parameter int unsigned SEL_W     = $clog2(NUM_SYM),
  parameter int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             led_out
);

  localparam int unsigned GapW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

  state_e               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d, sh_q, sh_d;
  logic [LEN_W-1:0]     len_q, len_d, bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic                 led_q, led_d, busy_q, busy_d, done_q, done_d;
  logic                 accept, unit_tick;
  logic [MAX_LEN-1:0]   sel_pat;
  logic [LEN_W-1:0]     sel_len;

  // Out-of-range selects resolve to an empty (gap-only) entry.
  always_comb begin
    sel_pat = '0;
    sel_len = '0;
    if (32'(sel) < NUM_SYM) begin
      sel_pat = MAX_LEN'(tbl_pattern(32'(sel)));
      sel_len = LEN_W'(tbl_len(32'(sel)));
    end
  end

  assign accept = (state_q == StIdle) && start && !abort;

  rate_divider #(
    .DIV(TICK_DIV)
  ) u_div (
    .clk   (CLOCK_50),
    .resetn(resetn),
    .load  (accept),
    .en    (state_q != StIdle),
    .tick  (unit_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      sh_q      <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pat_d     = sel_pat;
          sh_d      = sel_pat;
          len_d     = sel_len;
          bit_cnt_d = '0;
          gap_cnt_d = GapW'(GAP_UNITS - 1);
          state_d   = (sel_len == '0) ? StGap : StSend;
        end
      end
      StSend: begin
        if (unit_tick) begin
          if (bit_cnt_q == len_q - LEN_W'(1)) begin
            state_d   = StGap;
            gap_cnt_d = GapW'(GAP_UNITS - 1);
          end else begin
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
            sh_d      = sh_q >> 1;
          end
        end
      end
      StGap: begin
        if (unit_tick) begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GapW'(1);
          end else if (repeat_en) begin
            bit_cnt_d = '0;
            sh_d      = pat_q;
            gap_cnt_d = GapW'(GAP_UNITS - 1);
            state_d   = (len_q == '0) ? StGap : StSend;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy_d = (state_d != StIdle);
    led_d  = (state_d == StSend) && sh_d[0];
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_morse_tx_core.sv
// Bench for morse_tx_core: per-cycle {busy, led, done} expectations are queued when a start is
// driven and compared at each falling edge while the queue is non-empty.
module tb_morse_tx_core;

  localparam int TICK = 4;
  localparam int GAPU = 3;
  localparam int NSYM = 6;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            resetn, start, repeat_en, abort;
  logic [SELW-1:0] sel;
  logic            busy, done, led_out;

  morse_tx_core #(
    .TICK_DIV (TICK),
    .MAX_LEN  (16),
    .NUM_SYM  (NSYM),
    .GAP_UNITS(GAPU)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .sel      (sel),
    .start    (start),
    .repeat_en(repeat_en),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;  // {busy, led_out, done}
    string      tag;
  } exp_t;

  typedef struct {
    int    sel;
    string code;
    string name;
  } vec_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      checks++;
      if ({busy, led_out, done} !== e_mon.v) begin
        errors++;
        $display("FAIL %s t=%0t {busy,led,done} got %b expected %b", e_mon.tag, $time,
                 {busy, led_out, done}, e_mon.v);
      end
    end
  end

  task automatic push_n(input logic [2:0] v, input string tag, input int n);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    repeat (n) exp_q.push_back(e);
  endtask

  // Expand dot/dash text into unit bits and queue the full transaction, done cycle included.
  task automatic push_sym(input string code, input int passes, input string tag);
    logic bits[$];
    for (int i = 0; i < code.len(); i++) begin
      if (i > 0) bits.push_back(1'b0);
      if (code.getc(i) == ".") begin
        bits.push_back(1'b1);
      end else begin
        repeat (3) bits.push_back(1'b1);
      end
    end
    for (int p = 0; p < passes; p++) begin
      foreach (bits[b]) push_n({1'b1, bits[b], 1'b0}, tag, TICK);
      push_n(3'b100, tag, GAPU * TICK);
    end
    push_n(3'b001, tag, 1);
  endtask

  task automatic wait_left(input int left);
    int budget = 2000;
    while (exp_q.size() > left && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() > left) begin
      checks++;
      errors++;
      $display("FAIL timeout queue=%0d expected<=%0d", exp_q.size(), left);
      exp_q.delete();
    end
  endtask

  // Drive start in the current cycle (the done cycle of a previous symbol, if any).
  task automatic start_sym(input int s, input string code, input int passes, input string tag);
    wait_left(1);
    sel   = SELW'(s);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel   = SELW'($urandom);
    push_sym(code, passes, tag);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, "..", "I"};
    vecs[1] = '{1, ".---", "J"};
    vecs[2] = '{2, "-.-", "K"};
    vecs[3] = '{3, ".-..", "L"};
    vecs[4] = '{4, "--", "M"};
    vecs[5] = '{5, "-.", "N"};
    vecs[6] = '{6, "", "sel6"};
    vecs[7] = '{7, "", "sel7"};

    resetn = 1'b0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0; sel = '0;
    @(posedge clk);
    #1;
    push_n(3'b000, "reset", 2);
    wait_left(0);
    resetn = 1'b1;

    // Back-to-back table, including out-of-range selects (gap only).
    foreach (vecs[i]) start_sym(vecs[i].sel, vecs[i].code, 1, vecs[i].name);
    wait_left(0);
    push_n(3'b000, "idle_after_table", 2);
    wait_left(0);

    // J repeats twice then stops: 3 passes of 64 cycles, single done.
    repeat_en = 1'b1;
    start_sym(1, ".---", 3, "repeat_J");
    wait_left(60);
    repeat_en = 1'b0;
    wait_left(0);

    // Abort during cycle 6 of K; start again in cycle 10.
    sel = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_n(3'b110, "abort_K", 6);
    push_n(3'b000, "abort_idle", 3);
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start_sym(0, "..", 1, "after_abort");
    wait_left(0);

    // Abort wins over start in the same idle cycle.
    sel = 3'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    push_n(3'b000, "abort_vs_start", 3);
    wait_left(0);

    // start/sel noise while M is busy must not disturb it.
    start_sym(4, "--", 1, "ignore_M");
    while (exp_q.size() > 1) begin
      start = 1'($urandom_range(0, 1));
      sel   = SELW'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_left(0);
    push_n(3'b000, "ignore_after", 2);
    wait_left(0);

    // Reset held for two edges in the middle of L.
    sel = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_n(3'b110, "rst_L", 4);
    push_n(3'b100, "rst_L", 2);
    push_n(3'b000, "rst_idle", 2);
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b1;
    start_sym(5, "-.", 1, "after_rst");
    wait_left(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_tx_core.md
# morse_tx_core

Parametrised Morse-code transmitter core. It holds a table of NUM_SYM variable-length on/off patterns, accepts a symbol select with a start request, and plays the selected pattern MSB-agnostically (bit 0 first) on a single output at one bit per unit tick. Each symbol is followed by an inter-symbol gap and can repeat until stopped. It sits between board-level switch/key debouncing and an LED or buzzer driver, replacing fixed-rate, fixed-length shift-out logic.

## Interface
- TICK_DIV, 25000000: CLOCK_50 cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- MAX_LEN, 16: maximum pattern length in units.
- NUM_SYM, 8: number of table entries.
- GAP_UNITS, 3: low units appended after each symbol; must be ≥ 1.
- SEL_W, $clog2(NUM_SYM): select width (derived).
- LEN_W, $clog2(MAX_LEN+1): length width (derived).

Ports:
- CLOCK_50, input, 1: the single clock.
- resetn, input, 1: synchronous, active-low reset. Sampled only on the CLOCK_50 rising edge.
- sel, input, SEL_W: symbol index, sampled only when a start is accepted.
- start, input, 1: request; accepted only in IDLE.
- repeat_en, input, 1: sampled at the end of each gap.
- abort, input, 1: synchronous stop.
- busy, output, 1: high in SEND and GAP.
- done, output, 1: one-cycle pulse on normal completion.
- led_out, output, 1: Morse output (1 = on).

## Operation
- States:
  - IDLE: led_out=0, busy=0.
  - SEND: led_out = pattern bit at bit_cnt.
  - GAP: led_out=0.
- IDLE & start:
  - Latch pattern[sel] and len[sel].
  - Load divider with TICK_DIV-1 and set bit_cnt=0.
  - Go to SEND. If latched len==0, go directly to GAP instead.
- The divider decrements every cycle in SEND and GAP. A unit ends in the cycle where the divider is 0, and the divider reloads to TICK_DIV-1 on that edge.
- End of a unit in SEND:
  - If bit_cnt==len-1, go to GAP with gap_cnt=GAP_UNITS-1.
  - Otherwise increment bit_cnt.
- End of a unit in GAP:
  - If gap_cnt≠0, decrement gap_cnt.
  - Else if repeat_en=1, go to SEND and replay the latched pattern from bit 0. sel is not re-sampled.
  - Else go to IDLE and pulse done for one cycle.
- start while busy is ignored. Changes to sel while busy have no effect.
- abort=1 in any state: go to IDLE next edge with led_out=0 and no done pulse. abort has priority over start in the same cycle.
- resetn=0 forces IDLE, clears divider and counters, and drives busy=0, done=0, led_out=0. It has priority over abort and start.
- Table entries with len > MAX_LEN are illegal. Entries with sel ≥ NUM_SYM select an all-zero, len-0 entry (gap only).

## Timing
- Start accepted at edge 0 → busy=1 and led_out=bit0 from cycle 1.
- Each pattern bit is held exactly TICK_DIV cycles.
- Symbol duration: (len+GAP_UNITS)·TICK_DIV cycles.
- done is high in the first IDLE cycle, the same cycle busy falls.
- Back-to-back operation: start asserted in the done cycle is accepted, so there is no dead cycle beyond the done cycle.
- Repeat: bit0 of the next pass follows the last gap cycle with no extra idle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package morse_pkg holds:
  - state encoding constants (IDLE/SEND/GAP);
  - default pattern and length tables for letters I–P, bit 0 first, with dot=1, dash=111, intra-gap=0.
- Table lengths in morse_pkg: I 3, J 13, K 9, L 9, M 7, N 5, O 11, P 11.
- Sub-module rate_divider generates the unit tick:
  - parameter DIV;
  - inputs load and en;
  - output tick, high when the count is 0.

## Test plan
All scenarios use TICK_DIV=4, GAP_UNITS=3.
- Reset: resetn=0 for 2 cycles mid-SEND → next cycle busy=0, led_out=0, done=0. A subsequent start works normally.
- I (sel=0), start at edge 0, repeat_en=0 → led_out cycles 1–4 =1, 5–8 =0, 9–12 =1, 13–24 =0; done=1 only in cycle 25; busy high cycles 1–24.
- Repeat: J with repeat_en=1 for 2 passes, then 0 → period 64 cycles; bit0 of pass 2 at cycle 65; done exactly once, after pass 3 ends.
- Abort: abort at cycle 6 of K → IDLE at cycle 7, led_out=0, no done. start at cycle 10 is accepted.
- Ignored inputs: start and sel toggled while busy on M → output identical to undisturbed M (led pattern 1110111, 40 cycles total), single done.
- Edge selects: sel ≥ NUM_SYM with NUM_SYM=6, or a len-0 entry → busy for 12 cycles, led_out stays 0, done pulse.
